// File: rtl/cpu_pkg.sv
// Shared opcode, ALU code and sequencer state definitions.
// Build with MUL_DIV_EN to add MUL/DIV and the T6 state.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_NEG  = 5'b01010;
    localparam logic [4:0] ALU_NOT  = 5'b01011;
    localparam logic [4:0] ALU_MUL  = 5'b01110;
    localparam logic [4:0] ALU_DIV  = 5'b01111;

    typedef enum logic [2:0] {
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
`ifdef MUL_DIV_EN
        S_T6,
`endif
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_BIN,
        CLS_UNA,
        CLS_MD,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

    typedef struct packed {
        logic       pc_out;
        logic       mdr_out;
        logic       zlo_out;
        logic       zhi_out;
        logic       pc_in;
        logic       mdr_in;
        logic       mar_in;
        logic       ir_in;
        logic       y_in;
        logic       zlo_in;
        logic       zhi_in;
        logic       lo_in;
        logic       hi_in;
        logic       inc_pc;
        logic       read;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic [4:0] control;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/op_decode.sv
// Opcode classifier: maps a latched opcode to class and ALU code.
// MUL/DIV decode only when MUL_DIV_EN is defined.
module op_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [4:0] alu_code,
    output logic       legal
);

    always_comb begin
        op_class = CLS_ILL;
        alu_code = ALU_NONE;
        case (opcode)
            OP_ADD: begin op_class = CLS_BIN; alu_code = ALU_ADD; end
            OP_SUB: begin op_class = CLS_BIN; alu_code = ALU_SUB; end
            OP_AND: begin op_class = CLS_BIN; alu_code = ALU_AND; end
            OP_OR:  begin op_class = CLS_BIN; alu_code = ALU_OR;  end
            OP_NEG: begin op_class = CLS_UNA; alu_code = ALU_NEG; end
            OP_NOT: begin op_class = CLS_UNA; alu_code = ALU_NOT; end
`ifdef MUL_DIV_EN
            OP_MUL: begin op_class = CLS_MD;  alu_code = ALU_MUL; end
            OP_DIV: begin op_class = CLS_MD;  alu_code = ALU_DIV; end
`endif
            OP_HALT: op_class = CLS_HALT;
            default: ;
        endcase
    end

    assign legal = (op_class != CLS_ILL);

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, execute T3-T6, HALT.
// MUL_DIV_EN enables MUL/DIV (T6, ZHI/LO/HI strobes).
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        ZLO_Out,
    output logic        ZHI_Out,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        MAR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        ZLO_In,
    output logic        ZHI_In,
    output logic        LO_In,
    output logic        HI_In,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_In,
    output logic        R_Out,
    output logic [4:0]  CONTROL,
    output logic        Run,
    output logic        Illegal
);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] opcode_q;
    logic       clr_q;
    op_class_t  op_class;
    logic [4:0] alu_code;
    logic       legal;
    ctrl_t      ctl;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];

    op_decode u_op_decode (
        .opcode   (opcode_q),
        .op_class (op_class),
        .alu_code (alu_code),
        .legal    (legal)
    );

    // clr_q keeps outputs quiet for every cycle that follows a Clear edge
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state    <= S_T0;
            opcode_q <= OP_ADD;
            clr_q    <= 1'b1;
        end else begin
            state <= state_nxt;
            clr_q <= 1'b0;
            if (state == S_T2)
                opcode_q <= IR[31:27];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_T0: state_nxt = Stop ? S_HALT : S_T1;
            S_T1: state_nxt = S_T2;
            S_T2: state_nxt = S_T3;
            S_T3: begin
                if (!legal)
                    state_nxt = S_T0;
                else if (op_class == CLS_HALT)
                    state_nxt = S_HALT;
                else
                    state_nxt = S_T4;
            end
            S_T4: state_nxt = S_T5;
`ifdef MUL_DIV_EN
            S_T5: state_nxt = (op_class == CLS_MD) ? S_T6 : S_T0;
            S_T6: state_nxt = S_T0;
`else
            S_T5: state_nxt = S_T0;
`endif
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_T0;
        endcase
        // the first visible cycle after Clear falls is a full T0
        if (clr_q)
            state_nxt = S_T0;
    end

    always_comb begin
        ctl = '0;
        if (!clr_q) begin
            unique case (state)
                S_T0: begin
                    ctl.pc_out = 1'b1;
                    ctl.mar_in = 1'b1;
                    ctl.inc_pc = 1'b1;
                    ctl.zlo_in = 1'b1;
                end
                S_T1: begin
                    ctl.zlo_out = 1'b1;
                    ctl.pc_in   = 1'b1;
                    ctl.read    = 1'b1;
                    ctl.mdr_in  = 1'b1;
                end
                S_T2: begin
                    ctl.mdr_out = 1'b1;
                    ctl.ir_in   = 1'b1;
                end
                S_T3: begin
                    if (!legal) begin
                        ctl.illegal = 1'b1;
                    end else if (op_class == CLS_BIN ||
                                 op_class == CLS_UNA) begin
                        ctl.grb   = 1'b1;
                        ctl.r_out = 1'b1;
                        ctl.y_in  = 1'b1;
`ifdef MUL_DIV_EN
                    end else if (op_class == CLS_MD) begin
                        ctl.gra   = 1'b1;
                        ctl.r_out = 1'b1;
                        ctl.y_in  = 1'b1;
`endif
                    end
                end
                S_T4: begin
                    ctl.control = alu_code;
                    ctl.zlo_in  = 1'b1;
                    if (op_class == CLS_BIN) begin
                        ctl.grc   = 1'b1;
                        ctl.r_out = 1'b1;
                    end
`ifdef MUL_DIV_EN
                    if (op_class == CLS_MD) begin
                        ctl.grb    = 1'b1;
                        ctl.r_out  = 1'b1;
                        ctl.zhi_in = 1'b1;
                    end
`endif
                end
                S_T5: begin
                    ctl.zlo_out = 1'b1;
`ifdef MUL_DIV_EN
                    if (op_class == CLS_MD) begin
                        ctl.lo_in = 1'b1;
                    end else begin
                        ctl.gra  = 1'b1;
                        ctl.r_in = 1'b1;
                    end
`else
                    ctl.gra  = 1'b1;
                    ctl.r_in = 1'b1;
`endif
                end
`ifdef MUL_DIV_EN
                S_T6: begin
                    ctl.zhi_out = 1'b1;
                    ctl.hi_in   = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign PC_Out  = ctl.pc_out;
    assign MDR_Out = ctl.mdr_out;
    assign ZLO_Out = ctl.zlo_out;
    assign ZHI_Out = ctl.zhi_out;
    assign PC_In   = ctl.pc_in;
    assign MDR_In  = ctl.mdr_in;
    assign MAR_In  = ctl.mar_in;
    assign IR_In   = ctl.ir_in;
    assign Y_In    = ctl.y_in;
    assign ZLO_In  = ctl.zlo_in;
    assign ZHI_In  = ctl.zhi_in;
    assign LO_In   = ctl.lo_in;
    assign HI_In   = ctl.hi_in;
    assign IncPC   = ctl.inc_pc;
    assign Read    = ctl.read;
    assign Gra     = ctl.gra;
    assign Grb     = ctl.grb;
    assign Grc     = ctl.grc;
    assign R_In    = ctl.r_in;
    assign R_Out   = ctl.r_out;
    assign CONTROL = ctl.control;
    assign Illegal = ctl.illegal;
    assign Run     = !clr_q && (state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (table + random vs model).
// Honours MUL_DIV_EN when compiled with the same define as the RTL.
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic [31:0] IR = '0;
    logic        Stop = 1'b0;
    logic PC_Out, MDR_Out, ZLO_Out, ZHI_Out;
    logic PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, ZHI_In, LO_In, HI_In;
    logic IncPC, Read, Gra, Grb, Grc, R_In, R_Out, Run, Illegal;
    logic [4:0] CONTROL;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out),
        .ZHI_Out(ZHI_Out), .PC_In(PC_In), .MDR_In(MDR_In),
        .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In),
        .ZHI_In(ZHI_In), .LO_In(LO_In), .HI_In(HI_In), .IncPC(IncPC),
        .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_In(R_In),
        .R_Out(R_Out), .CONTROL(CONTROL), .Run(Run), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // observation word: [19:0] strobes, [24:20] CONTROL, 25 Illegal, 26 Run
    localparam logic [26:0] M_PC_OUT  = 27'd1 << 0;
    localparam logic [26:0] M_MDR_OUT = 27'd1 << 1;
    localparam logic [26:0] M_ZLO_OUT = 27'd1 << 2;
    localparam logic [26:0] M_ZHI_OUT = 27'd1 << 3;
    localparam logic [26:0] M_PC_IN   = 27'd1 << 4;
    localparam logic [26:0] M_MDR_IN  = 27'd1 << 5;
    localparam logic [26:0] M_MAR_IN  = 27'd1 << 6;
    localparam logic [26:0] M_IR_IN   = 27'd1 << 7;
    localparam logic [26:0] M_Y_IN    = 27'd1 << 8;
    localparam logic [26:0] M_ZLO_IN  = 27'd1 << 9;
    localparam logic [26:0] M_ZHI_IN  = 27'd1 << 10;
    localparam logic [26:0] M_LO_IN   = 27'd1 << 11;
    localparam logic [26:0] M_HI_IN   = 27'd1 << 12;
    localparam logic [26:0] M_INCPC   = 27'd1 << 13;
    localparam logic [26:0] M_READ    = 27'd1 << 14;
    localparam logic [26:0] M_GRA     = 27'd1 << 15;
    localparam logic [26:0] M_GRB     = 27'd1 << 16;
    localparam logic [26:0] M_GRC     = 27'd1 << 17;
    localparam logic [26:0] M_R_IN    = 27'd1 << 18;
    localparam logic [26:0] M_R_OUT   = 27'd1 << 19;
    localparam logic [26:0] M_ILL     = 27'd1 << 25;
    localparam logic [26:0] M_RUN     = 27'd1 << 26;
    localparam logic [26:0] W_T0 = M_RUN | M_PC_OUT | M_MAR_IN | M_INCPC | M_ZLO_IN;

    function automatic logic [26:0] obs();
        return {Run, Illegal, CONTROL, R_Out, R_In, Grc, Grb, Gra, Read,
                IncPC, HI_In, LO_In, ZHI_In, ZLO_In, Y_In, IR_In, MAR_In,
                MDR_In, PC_In, ZHI_Out, ZLO_Out, MDR_Out, PC_Out};
    endfunction

    function automatic logic [26:0] cw(input logic [4:0] c);
        return {2'b00, c, 20'b0};
    endfunction

    task automatic check(input string name, input logic [26:0] act,
                         input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected observation word for every cycle from T0
    logic [26:0] exp_q[$];

    function automatic void model_instr(input logic [4:0] op, input bit stop,
                                        output bit halts);
        int alu;
        halts = stop;
        exp_q.push_back(W_T0);
        if (stop) return;
        exp_q.push_back(M_RUN | M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN);
        exp_q.push_back(M_RUN | M_MDR_OUT | M_IR_IN);
        if (op <= 5'd3) begin
            alu = int'(op) + 3;
            exp_q.push_back(M_RUN | M_GRB | M_R_OUT | M_Y_IN);
            exp_q.push_back(M_RUN | M_GRC | M_R_OUT | M_ZLO_IN | cw(5'(alu)));
            exp_q.push_back(M_RUN | M_ZLO_OUT | M_GRA | M_R_IN);
        end else if (op == 5'd16 || op == 5'd17) begin
            alu = int'(op) - 6;
            exp_q.push_back(M_RUN | M_GRB | M_R_OUT | M_Y_IN);
            exp_q.push_back(M_RUN | M_ZLO_IN | cw(5'(alu)));
            exp_q.push_back(M_RUN | M_ZLO_OUT | M_GRA | M_R_IN);
`ifdef MUL_DIV_EN
        end else if (op == 5'd14 || op == 5'd15) begin
            exp_q.push_back(M_RUN | M_GRA | M_R_OUT | M_Y_IN);
            exp_q.push_back(M_RUN | M_GRB | M_R_OUT | M_ZLO_IN | M_ZHI_IN | cw(op));
            exp_q.push_back(M_RUN | M_ZLO_OUT | M_LO_IN);
            exp_q.push_back(M_RUN | M_ZHI_OUT | M_HI_IN);
`endif
        end else if (op == 5'd27) begin
            exp_q.push_back(M_RUN);
            halts = 1'b1;
        end else begin
            exp_q.push_back(M_RUN | M_ILL);
        end
    endfunction

    // Called at the falling edge inside a T0 cycle; returns at the next one
    task automatic run_instr(input string name, input logic [4:0] op,
                             input bit stop, output bit halts);
        exp_q.delete();
        model_instr(op, stop, halts);
        IR = {op, 27'($urandom)};
        Stop = stop;
        foreach (exp_q[i]) begin
            check(name, obs(), exp_q[i]);
            @(negedge Clock);
            Stop = 1'b0;
        end
    endtask

    task automatic check_halt(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            check(name, obs(), '0);
            Stop = 1'($urandom_range(0, 1));
            @(negedge Clock);
        end
        Stop = 1'b0;
    endtask

    task automatic do_clear(input int n);
        Clear = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            check("clear_quiet", obs() & ~M_RUN, '0);
        end
        Clear = 1'b0;
        @(negedge Clock);
    endtask

    typedef struct {
        logic [4:0] op;
        int         len;
        logic [4:0] ctl4;
        int         nill;
    } vec_t;

    vec_t tab[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   h;
        int   cyc;
        int   nill;
        logic [4:0] c4;
        logic [4:0] op;

        tab[0] = '{5'b00000, 6, 5'b00011, 0};
        tab[1] = '{5'b00001, 6, 5'b00100, 0};
        tab[2] = '{5'b00010, 6, 5'b00101, 0};
        tab[3] = '{5'b00011, 6, 5'b00110, 0};
        tab[4] = '{5'b10000, 6, 5'b01010, 0};
        tab[5] = '{5'b10001, 6, 5'b01011, 0};
        tab[6] = '{5'b11111, 4, 5'b00000, 1};
        tab[7] = '{5'b00100, 4, 5'b00000, 1};
`ifdef MUL_DIV_EN
        tab[8] = '{5'b01110, 7, 5'b01110, 0};
        tab[9] = '{5'b01111, 7, 5'b01111, 0};
`else
        tab[8] = '{5'b01110, 4, 5'b00000, 1};
        tab[9] = '{5'b01111, 4, 5'b00000, 1};
`endif

        // reset: two Clear cycles, then NEG with full per-cycle check
        do_clear(2);
        check("reset_t0", obs(), W_T0);
        run_instr("neg_seq", 5'b10000, 1'b0, h);
        check("neg_back_t0", obs(), W_T0);
        run_instr("add_seq", 5'b00000, 1'b0, h);

        // table: cycle count, T4 CONTROL and Illegal pulse count per opcode
        foreach (tab[k]) begin
            IR = {tab[k].op, 27'h0};
            cyc = 0;
            nill = 0;
            c4 = '0;
            do begin
                if (cyc == 4) c4 = CONTROL;
                if (Illegal) nill++;
                @(negedge Clock);
                cyc++;
            end while (!PC_Out && cyc < 12);
            check_int($sformatf("tab_len_%b", tab[k].op), cyc, tab[k].len);
            check_int($sformatf("tab_ctl_%b", tab[k].op), int'(c4), int'(tab[k].ctl4));
            check_int($sformatf("tab_ill_%b", tab[k].op), nill, tab[k].nill);
        end

        // Stop in T0: T0 completes, then frozen HALT until Clear
        run_instr("stop_t0", 5'b00000, 1'b1, h);
        check_halt("stop_halt", 10);
        do_clear(2);

        // HALT opcode
        run_instr("halt_op", 5'b11011, 1'b0, h);
        check_halt("halt_op_halt", 4);
        do_clear(1);

        // undecoded opcode, then MUL (illegal or T6 depending on build)
        run_instr("illegal_op", 5'b11111, 1'b0, h);
        run_instr("mul_op", 5'b01110, 1'b0, h);

        // Clear raised in T4 of SUB
        exp_q.delete();
        model_instr(5'b00001, 1'b0, h);
        IR = {5'b00001, 27'h5a5a5a5};
        for (int i = 0; i < 5; i++) begin
            check("sub_pre_clear", obs(), exp_q[i]);
            if (i < 4) @(negedge Clock);
        end
        Clear = 1'b1;
        @(negedge Clock);
        check("clr_mid_quiet", obs() & ~M_RUN, '0);
        Clear = 1'b0;
        @(negedge Clock);
        check("clr_mid_t0", obs(), W_T0);

        // randomized instruction stream against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0)
                op = 5'($urandom_range(0, 31));
            else
                case ($urandom_range(0, 7))
                    0: op = 5'b00000;
                    1: op = 5'b00001;
                    2: op = 5'b00010;
                    3: op = 5'b00011;
                    4: op = 5'b10000;
                    5: op = 5'b10001;
                    6: op = 5'b01110;
                    default: op = 5'b01111;
                endcase
            run_instr("rand", op, ($urandom_range(0, 9) == 0), h);
            if (h) begin
                check_halt("rand_halt", $urandom_range(1, 4));
                do_clear($urandom_range(1, 3));
            end else if ($urandom_range(0, 15) == 0) begin
                do_clear(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: Clock  in  1  single system clock, all state changes on rising edge.
REQ-002 SHALL have port: Clear  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-004 SHALL have port: Stop  in  1  halt request, sampled in T0.
REQ-005 SHALL have ports: PC_Out, MDR_Out, ZLO_Out, ZHI_Out  out  1 each  bus source selects.
REQ-006 SHALL have ports: PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, ZHI_In, LO_In, HI_In  out  1 each  register load enables.
REQ-007 SHALL have ports: IncPC, Read  out  1 each  PC increment, memory read.
REQ-008 SHALL have ports: Gra, Grb, Grc, R_In, R_Out  out  1 each  register-field select and general-register strobes.
REQ-009 SHALL have port: CONTROL  out  5  ALU operation code to Datapath.
REQ-010 SHALL have ports: Run  out  1  high while sequencing; Illegal  out  1  one-cycle pulse on undecoded opcode.

Function
REQ-011 SHALL be a Moore FSM: exactly one state per Clock; all outputs decoded from the state register plus latched opcode only.
REQ-012 SHALL use states T0..T6 and HALT; T0->T1->T2 unconditionally.
REQ-013 T0 SHALL assert PC_Out, MAR_In, IncPC, ZLO_In.
REQ-014 T1 SHALL assert ZLO_Out, PC_In, Read, MDR_In.
REQ-015 T2 SHALL assert MDR_Out, IR_In; opcode SHALL be latched from IR at the first edge of T3 (IR valid after T2 edge) and held until next T0.
REQ-016 Binary class (ADD 00000, SUB 00001, AND 00010, OR 00011): T3 Grb,R_Out,Y_In; T4 Grc,R_Out,CONTROL=op code,ZLO_In; T5 ZLO_Out,Gra,R_In; then T0.
REQ-017 Unary class (NEG 10000, NOT 10001): T3 Grb,R_Out,Y_In; T4 CONTROL=op code,ZLO_In (no bus source); T5 ZLO_Out,Gra,R_In; then T0.
REQ-018 ALU codes SHALL be ADD 00011, SUB 00100, AND 00101, OR 00110, NEG 01010, NOT 01011; CONTROL SHALL be 00000 in every state other than T4.
REQ-019 HALT opcode 11011 SHALL go T3->HALT with no strobes in T3.
REQ-020 Undecoded opcode SHALL pulse Illegal in T3, assert no strobes, return to T0.
REQ-021 Stop high in T0 SHALL complete T0 normally and go to HALT instead of T1.
REQ-022 HALT SHALL hold all strobes 0, Run=0, until Clear; Stop ignored there.
REQ-023 Clear has priority over every transition, including mid-instruction (T1..T6) and HALT.

Reset
REQ-024 Clear SHALL force state T0 and latched opcode 00000 at the next rising edge.
REQ-025 During Clear-high cycles all strobes, CONTROL and Illegal SHALL be 0, Run SHALL be 1 from the first cycle after Clear falls.

Configuration
REQ-026 Macro MUL_DIV_EN SHALL enable MUL 01110 (ALU 01110) and DIV 01111 (ALU 01111): T3 Gra,R_Out,Y_In; T4 Grb,R_Out,CONTROL,ZLO_In,ZHI_In; T5 ZLO_Out,LO_In; T6 ZHI_Out,HI_In; then T0.
REQ-027 Without MUL_DIV_EN, T6 SHALL not exist, MUL/DIV SHALL take the Illegal path, and ZHI_Out, ZHI_In, LO_In, HI_In SHALL be tied 0 (ports kept).

Structure
REQ-028 Package cpu_pkg SHALL hold opcode constants, ALU code constants, state encoding typedef.
REQ-029 Sub-module op_decode (combinational: opcode -> class, ALU code, legal) SHALL be instantiated once.

Verification
REQ-030 Clear 2 cycles then IR=32'h80000000 (NEG) -> T0..T5 strobes per REQ-013/014/015/017, CONTROL=01010 only in T4, back to T0 on 7th cycle.
REQ-031 IR=32'h00000000 (ADD) -> T4 shows Grc,R_Out,ZLO_In,CONTROL=00011; T5 Gra,R_In.
REQ-032 Stop=1 during T0 -> T0 strobes asserted, next state HALT, Run=0, outputs frozen 0 for 10 cycles.
REQ-033 Clear raised in T4 of SUB -> next cycle T0, CONTROL=00000, no R_In seen.
REQ-034 IR opcode 11111 -> Illegal pulse exactly 1 cycle in T3, then T0.
REQ-035 MUL_DIV_EN defined, opcode 01110 -> T6 asserts ZHI_Out,HI_In; undefined -> Illegal path.
